if_fetch_unit: RTL

- Producer side of the IF/ID stage register. Owns the PC, issues in-order instruction-memory requests, and buffers returned words.
- Presents {pc_plus4, instruction} to IF/ID, consuming one entry whenever the hazard unit allows IF/ID to advance.
- Applies branch/jump redirects in the same cycle the hazard unit flushes IF/ID.

---
 rtl/if_fetch_unit_pkg.sv | 26 ++
 rtl/if_fetch_unit_if.sv | 25 ++
 rtl/if_fetch_unit_fetch_buf_fifo.sv | 71 +++++++
 rtl/if_fetch_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package   : common_defs
// Purpose   : Shared constants, types and helpers for the instruction fetch
//             unit (buffer entry layout, NOP encoding, PC increment).
// Revision  : 1.0 - initial release
// ============================================================================
package common_defs;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  // One fetch-buffer entry as presented to IF/ID.
  typedef struct packed {
    logic [31:0]        pc_plus4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : if_fetch_unit_if
// Purpose   : Instruction-memory request/response channel.
//   req    - request valid            (fetch unit -> memory)
//   addr   - word-aligned address     (fetch unit -> memory)
//   ready  - request accepted         (memory -> fetch unit)
//   rvalid - in-order response valid  (memory -> fetch unit)
//   rdata  - instruction word         (memory -> fetch unit)
// Revision  : 1.0 - initial release
// ============================================================================
interface if_fetch_unit_if;
  import common_defs::*;

  logic               req;
  logic [31:0]        addr;
  logic               ready;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface
`default_nettype wire

// File: rtl/if_fetch_unit_fetch_buf_fifo.sv
`default_nettype none
// ============================================================================
// Module    : fetch_buf_fifo
// Purpose   : Small synchronous FIFO with a synchronous clear. Head entry is
//             presented combinationally (show-ahead).
// Ports     : clk, reset (async active-low), clear (drop all entries),
//             push/push_data, pop, head_data, count (0..DEPTH)
// Notes     : Push while full is ignored unless a pop frees the slot in the
//             same cycle; pop while empty is ignored. DEPTH is a power of two.
// Revision  : 1.0 - initial release
// ============================================================================
module fetch_buf_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  C_PONE  = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != C_DEPTH) | w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= push_data;
  end

  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module    : if_fetch_unit
// Purpose   : Producer side of the IF/ID register. Owns the PC, issues in-order
//             instruction-memory requests, buffers returned words and presents
//             {pc_plus4, instruction} to IF/ID.
// Ports     : clk, reset (async active-low)
//             pc_write            - IF/ID advance enable (0 = stall)
//             redirect/redirect_pc- taken branch/jump, same net as IF/ID flush
//             imem                - memory channel (master modport)
//             pc_plus4_out, instruction_out, fetch_valid - head entry to IF/ID
// Revision  : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import common_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pc_write,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  if_fetch_unit_if.master     imem,
  output logic [31:0]         pc_plus4_out,
  output logic [INSTR_W-1:0]  instruction_out,
  output logic                fetch_valid
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   C_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

  logic [31:0]      r_fetch_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;

  fetch_entry_t     w_buf_head;
  fetch_entry_t     w_buf_in;
  logic [CNT_W-1:0] w_buf_count;
  logic [31:0]      w_tag_head;
  logic [CNT_W-1:0] w_tag_count;

  logic             w_pop;
  logic             w_hs;
  logic             w_rsp;
  logic             w_rsp_drop;
  logic             w_rsp_keep;
  logic [CNT_W:0]   w_credit_used;
  logic [CNT_W-1:0] w_out_after_rsp;

  assign fetch_valid = (w_buf_count != '0);
  assign w_pop       = fetch_valid & pc_write & ~redirect;

  // The entry popped this cycle frees its slot immediately; counting it keeps
  // a two-entry buffer streaming one instruction per cycle at latency 1.
  assign w_credit_used = {1'b0, w_buf_count} + {1'b0, r_outstanding}
                       - {{CNT_W{1'b0}}, w_pop};

  assign imem.req  = reset & ~redirect & (w_credit_used < C_LIMIT);
  assign imem.addr = r_fetch_pc;
  assign w_hs      = imem.req & imem.ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp      = imem.rvalid & (r_outstanding != '0);
  assign w_rsp_drop = w_rsp & (r_drop_cnt != '0);
  assign w_rsp_keep = w_rsp & (r_drop_cnt == '0) & ~redirect & (w_tag_count != '0);

  assign w_out_after_rsp = r_outstanding - (w_rsp ? C_ONE : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect) begin
      // Everything still in flight belongs to the abandoned path. The drop
      // count is the whole outstanding total (it already includes any earlier
      // stale requests), so back-to-back redirects never double count.
      r_fetch_pc    <= word_align(redirect_pc);
      r_outstanding <= w_out_after_rsp;
      r_drop_cnt    <= w_out_after_rsp;
    end else begin
      if (w_hs) r_fetch_pc <= r_fetch_pc + PC_INC;
      r_outstanding <= w_out_after_rsp + (w_hs ? C_ONE : '0);
      if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - C_ONE;
    end
  end

  // Tags hold the PC of each live (non-dropped) request, oldest first; stale
  // responses always precede live ones, so they never consume a tag.
  fetch_buf_fifo #(
    .WIDTH (32),
    .DEPTH (BUF_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (w_hs),
    .push_data (r_fetch_pc),
    .pop       (w_rsp_keep),
    .head_data (w_tag_head),
    .count     (w_tag_count)
  );

  assign w_buf_in.pc_plus4 = w_tag_head + PC_INC;
  assign w_buf_in.instr    = imem.rdata;

  fetch_buf_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (w_rsp_keep),
    .push_data (w_buf_in),
    .pop       (w_pop),
    .head_data (w_buf_head),
    .count     (w_buf_count)
  );

  assign pc_plus4_out    = fetch_valid ? w_buf_head.pc_plus4 : 32'h0;
  assign instruction_out = fetch_valid ? w_buf_head.instr    : NOP_INSTR;

endmodule
`default_nettype wire
